// File: rtl/pixel_generator_if.sv
// pixel_generator_if: AXI4-Stream video master and AXI4-Lite control slave signals
// of the pixel generator; master is the generator side, slave the sink/CPU side.
interface pixel_generator_if;
    logic [31:0] out_stream_tdata;
    logic [3:0]  out_stream_tkeep;
    logic        out_stream_tlast;
    logic        out_stream_tuser;
    logic        out_stream_tvalid;
    logic        out_stream_tready;
    logic [7:0]  s_axi_lite_awaddr;
    logic        s_axi_lite_awvalid;
    logic        s_axi_lite_awready;
    logic [31:0] s_axi_lite_wdata;
    logic        s_axi_lite_wvalid;
    logic        s_axi_lite_wready;
    logic [1:0]  s_axi_lite_bresp;
    logic        s_axi_lite_bvalid;
    logic        s_axi_lite_bready;
    logic [7:0]  s_axi_lite_araddr;
    logic        s_axi_lite_arvalid;
    logic        s_axi_lite_arready;
    logic [31:0] s_axi_lite_rdata;
    logic [1:0]  s_axi_lite_rresp;
    logic        s_axi_lite_rvalid;
    logic        s_axi_lite_rready;
    modport master (
        output out_stream_tdata, out_stream_tkeep, out_stream_tlast, out_stream_tuser, out_stream_tvalid,
        input  out_stream_tready,
        input  s_axi_lite_awaddr, s_axi_lite_awvalid, s_axi_lite_wdata, s_axi_lite_wvalid, s_axi_lite_bready,
        input  s_axi_lite_araddr, s_axi_lite_arvalid, s_axi_lite_rready,
        output s_axi_lite_awready, s_axi_lite_wready, s_axi_lite_bresp, s_axi_lite_bvalid,
        output s_axi_lite_arready, s_axi_lite_rdata, s_axi_lite_rresp, s_axi_lite_rvalid
    );
    modport slave (
        input  out_stream_tdata, out_stream_tkeep, out_stream_tlast, out_stream_tuser, out_stream_tvalid,
        output out_stream_tready,
        output s_axi_lite_awaddr, s_axi_lite_awvalid, s_axi_lite_wdata, s_axi_lite_wvalid, s_axi_lite_bready,
        output s_axi_lite_araddr, s_axi_lite_arvalid, s_axi_lite_rready,
        input  s_axi_lite_awready, s_axi_lite_wready, s_axi_lite_bresp, s_axi_lite_bvalid,
        input  s_axi_lite_arready, s_axi_lite_rdata, s_axi_lite_rresp, s_axi_lite_rvalid
    );
endinterface

// File: rtl/pixel_generator.sv
// pixel_generator: endless X_SIZE x Y_SIZE raster on AXI4-Stream (SOF on tuser, EOL on tlast)
// with colour offsets from an AXI4-Lite register file, applied only at frame start.
module pixel_generator #(
    parameter int X_SIZE = 640,
    parameter int Y_SIZE = 480
) (
    input logic               out_stream_aclk,
    input logic               s_axi_lite_aclk,
    input logic               axi_resetn,
    input logic               periph_resetn,
    pixel_generator_if.master bus
);
    localparam int XW = $clog2(X_SIZE);
    localparam int YW = $clog2(Y_SIZE);
    logic          w_rst_n;
    logic          w_load, w_sof, w_eol, w_eof;
    logic [23:0]   w_off;
    logic          w_unused;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [7:0]    r_frame;
    logic [23:0]   r_shadow;
    logic [31:0]   r_tdata;
    logic          r_tvalid, r_tuser, r_tlast;
    logic [31:0]   r_regs [8];
    logic          r_awready, r_bvalid, r_arready, r_rvalid;
    logic [31:0]   r_rdata;
    assign w_rst_n  = axi_resetn & periph_resetn;
    assign w_load   = !r_tvalid || bus.out_stream_tready;
    assign w_sof    = r_x == '0 && r_y == '0;
    assign w_eol    = r_x == XW'(X_SIZE - 1);
    assign w_eof    = r_y == YW'(Y_SIZE - 1);
    // SOF word already uses the freshly latched offsets so the whole frame is consistent
    assign w_off    = w_sof ? r_regs[0][23:0] : r_shadow;
    assign w_unused = ^{s_axi_lite_aclk, bus.s_axi_lite_awaddr[7:5], bus.s_axi_lite_awaddr[1:0],
                        bus.s_axi_lite_araddr[7:5], bus.s_axi_lite_araddr[1:0]};
    always_ff @(posedge out_stream_aclk or negedge w_rst_n)
        if (!w_rst_n) begin
            r_x      <= '0;
            r_y      <= '0;
            r_frame  <= '0;
            r_shadow <= '0;
            r_tdata  <= '0;
            r_tvalid <= 1'b0;
            r_tuser  <= 1'b0;
            r_tlast  <= 1'b0;
        end else if (w_load) begin
            r_tvalid <= 1'b1;
            r_tuser  <= w_sof;
            r_tlast  <= w_eol;
            r_tdata  <= {8'h00, 8'(r_x) + w_off[7:0], 8'(r_y) + w_off[15:8], r_frame + w_off[23:16]};
            r_shadow <= w_off;
            r_x      <= w_eol ? '0 : r_x + XW'(1);
            r_y      <= w_eol ? (w_eof ? '0 : r_y + YW'(1)) : r_y;
            r_frame  <= (w_eol && w_eof) ? r_frame + 8'd1 : r_frame;
        end
    always_ff @(posedge out_stream_aclk or negedge w_rst_n)
        if (!w_rst_n) begin
            for (int i = 0; i < 8; i++) r_regs[i] <= '0;
            r_awready <= 1'b0;
            r_bvalid  <= 1'b0;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_awready <= bus.s_axi_lite_awvalid && bus.s_axi_lite_wvalid && !r_bvalid && !r_awready;
            if (r_awready) r_regs[bus.s_axi_lite_awaddr[4:2]] <= bus.s_axi_lite_wdata;
            r_bvalid  <= r_awready || (r_bvalid && !bus.s_axi_lite_bready);
            r_arready <= bus.s_axi_lite_arvalid && !r_rvalid && !r_arready;
            if (r_arready) r_rdata <= r_regs[bus.s_axi_lite_araddr[4:2]];
            r_rvalid  <= r_arready || (r_rvalid && !bus.s_axi_lite_rready);
        end
    assign bus.out_stream_tdata   = r_tdata;
    assign bus.out_stream_tkeep   = 4'hF;
    assign bus.out_stream_tlast   = r_tlast;
    assign bus.out_stream_tuser   = r_tuser;
    assign bus.out_stream_tvalid  = r_tvalid;
    assign bus.s_axi_lite_awready = r_awready;
    assign bus.s_axi_lite_wready  = r_awready;
    assign bus.s_axi_lite_bresp   = 2'b00;
    assign bus.s_axi_lite_bvalid  = r_bvalid;
    assign bus.s_axi_lite_arready = r_arready;
    assign bus.s_axi_lite_rdata   = r_rdata;
    assign bus.s_axi_lite_rresp   = 2'b00;
    assign bus.s_axi_lite_rvalid  = r_rvalid;
endmodule

// File: tb/tb_pixel_generator.sv
// tb_pixel_generator: directed bench for pixel_generator on a reduced 300x6 raster
// (keeps a full frame short while x still exceeds 8 bits).
module tb_pixel_generator;
    localparam int X = 300;
    localparam int Y = 6;
    logic clk = 1'b0;
    logic axi_resetn, periph_resetn;
    int total = 0, bad = 0;
    pixel_generator_if bus();
    pixel_generator #(.X_SIZE(X), .Y_SIZE(Y)) dut (
        .out_stream_aclk(clk),
        .s_axi_lite_aclk(clk),
        .axi_resetn(axi_resetn),
        .periph_resetn(periph_resetn),
        .bus(bus.master)
    );
    always #5 clk = ~clk;
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    // mode 0: always ready, 1: random ready, 2: ready every other cycle (one cycle after valid)
    task automatic run(input int a0, input int n, input int mode, input logic [7:0] fr,
                       input logic [23:0] off, input int exp_last, input int exp_user);
        int a = a0;
        int nl = 0;
        int nu = 0;
        logic [33:0] held;
        logic stall;
        bus.out_stream_tready = (mode == 1) ? 1'($urandom_range(0, 1)) : (mode == 0);
        for (int c = 0; c < 40000 && a < a0 + n; c++) begin
            if (bus.out_stream_tready) begin
                chk("tvalid", bus.out_stream_tvalid, 1);
                chk("tdata", bus.out_stream_tdata,
                    {8'h00, 8'(a % X) + off[7:0], 8'(a / X) + off[15:8], fr + off[23:16]});
                chk("tuser", bus.out_stream_tuser, a == 0);
                chk("tlast", bus.out_stream_tlast, a % X == X - 1);
                nl += int'(bus.out_stream_tlast);
                nu += int'(bus.out_stream_tuser);
                a++;
            end
            held  = {bus.out_stream_tuser, bus.out_stream_tlast, bus.out_stream_tdata};
            stall = !bus.out_stream_tready;
            step();
            if (stall) chk("hold", {bus.out_stream_tuser, bus.out_stream_tlast, bus.out_stream_tdata}, held);
            bus.out_stream_tready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : !bus.out_stream_tready;
        end
        bus.out_stream_tready = 1'b0;
        chk("accepted", a, a0 + n);
        chk("n_tlast", nl, exp_last);
        chk("n_tuser", nu, exp_user);
    endtask
    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data);
        bus.s_axi_lite_awaddr  = addr;
        bus.s_axi_lite_wdata   = data;
        bus.s_axi_lite_awvalid = 1'b1;
        bus.s_axi_lite_wvalid  = 1'b1;
        bus.s_axi_lite_bready  = 1'b0;
        step();
        chk("awready", bus.s_axi_lite_awready, 1);
        chk("wready", bus.s_axi_lite_wready, 1);
        step();
        chk("awready_drop", bus.s_axi_lite_awready, 0);
        chk("bvalid", bus.s_axi_lite_bvalid, 1);
        chk("bresp", bus.s_axi_lite_bresp, 0);
        bus.s_axi_lite_awvalid = 1'b0;
        bus.s_axi_lite_wvalid  = 1'b0;
        step();
        chk("bvalid_hold", bus.s_axi_lite_bvalid, 1);
        bus.s_axi_lite_bready = 1'b1;
        step();
        chk("bvalid_clear", bus.s_axi_lite_bvalid, 0);
        bus.s_axi_lite_bready = 1'b0;
    endtask
    task automatic axi_read(input logic [7:0] addr, input logic [31:0] exp);
        bus.s_axi_lite_araddr  = addr;
        bus.s_axi_lite_arvalid = 1'b1;
        bus.s_axi_lite_rready  = 1'b0;
        step();
        chk("arready", bus.s_axi_lite_arready, 1);
        chk("rvalid_early", bus.s_axi_lite_rvalid, 0);
        step();
        chk("arready_drop", bus.s_axi_lite_arready, 0);
        chk("rvalid", bus.s_axi_lite_rvalid, 1);
        chk("rdata", bus.s_axi_lite_rdata, exp);
        chk("rresp", bus.s_axi_lite_rresp, 0);
        bus.s_axi_lite_arvalid = 1'b0;
        step();
        chk("rvalid_hold", bus.s_axi_lite_rvalid, 1);
        chk("rdata_hold", bus.s_axi_lite_rdata, exp);
        bus.s_axi_lite_rready = 1'b1;
        step();
        chk("rvalid_clear", bus.s_axi_lite_rvalid, 0);
        bus.s_axi_lite_rready = 1'b0;
    endtask
    initial begin
        axi_resetn             = 1'b0;
        periph_resetn          = 1'b0;
        bus.out_stream_tready  = 1'b0;
        bus.s_axi_lite_awaddr  = '0;
        bus.s_axi_lite_awvalid = 1'b0;
        bus.s_axi_lite_wdata   = '0;
        bus.s_axi_lite_wvalid  = 1'b0;
        bus.s_axi_lite_bready  = 1'b0;
        bus.s_axi_lite_araddr  = '0;
        bus.s_axi_lite_arvalid = 1'b0;
        bus.s_axi_lite_rready  = 1'b0;
        repeat (3) step();
        chk("rst_tvalid", bus.out_stream_tvalid, 0);
        chk("rst_tdata", bus.out_stream_tdata, 0);
        chk("rst_tuser", bus.out_stream_tuser, 0);
        chk("rst_tlast", bus.out_stream_tlast, 0);
        chk("rst_tkeep", bus.out_stream_tkeep, 4'hF);
        chk("rst_awready", bus.s_axi_lite_awready, 0);
        chk("rst_bvalid", bus.s_axi_lite_bvalid, 0);
        chk("rst_arready", bus.s_axi_lite_arready, 0);
        chk("rst_rvalid", bus.s_axi_lite_rvalid, 0);
        chk("rst_rdata", bus.s_axi_lite_rdata, 0);
        axi_resetn    = 1'b1;
        periph_resetn = 1'b1;
        step();
        chk("first_tvalid", bus.out_stream_tvalid, 1);
        chk("first_tuser", bus.out_stream_tuser, 1);
        chk("first_tdata", bus.out_stream_tdata, 32'h0000_0000);
        run(0, 1800, 0, 8'd0, 24'h0, 6, 1);
        chk("sof1_tuser", bus.out_stream_tuser, 1);
        chk("sof1_tdata", bus.out_stream_tdata, 32'h0000_0001);
        run(0, 1800, 1, 8'd1, 24'h0, 6, 1);
        run(0, 1800, 2, 8'd2, 24'h0, 6, 1);
        run(0, 900, 0, 8'd3, 24'h0, 3, 1);
        axi_write(8'h00, 32'h0033_2211);
        chk("stall_tdata", bus.out_stream_tdata, 32'h0000_0303);
        chk("stall_tuser", bus.out_stream_tuser, 0);
        run(900, 900, 0, 8'd3, 24'h0, 3, 0);
        chk("sof4_tuser", bus.out_stream_tuser, 1);
        chk("sof4_tdata", bus.out_stream_tdata, 32'h0011_2237);
        axi_read(8'h00, 32'h0033_2211);
        axi_write(8'h1C, 32'hA5A5_5A5A);
        axi_read(8'hFC, 32'hA5A5_5A5A);
        axi_read(8'h04, 32'h0);
        fork
            axi_write(8'h08, 32'h1234_5678);
            axi_read(8'h08, 32'h0);
        join
        axi_read(8'h0B, 32'h1234_5678);
        run(0, 1800, 0, 8'd4, 24'h33_2211, 6, 1);
        run(0, 1000, 0, 8'd5, 24'h33_2211, 3, 1);
        periph_resetn = 1'b0;
        #1;
        chk("mid_rst_tvalid", bus.out_stream_tvalid, 0);
        chk("mid_rst_tdata", bus.out_stream_tdata, 0);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mid_rst_hold", bus.out_stream_tvalid, 0);
        end
        periph_resetn = 1'b1;
        step();
        chk("restart_tvalid", bus.out_stream_tvalid, 1);
        chk("restart_tuser", bus.out_stream_tuser, 1);
        chk("restart_tdata", bus.out_stream_tdata, 32'h0);
        axi_read(8'h00, 32'h0);
        run(0, 300, 1, 8'd0, 24'h0, 1, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
